// File: rtl/encap_packet_pkg.sv
// encap_packet_pkg: shared geometry, state encoding and frame slicing for the Aurora encap/decap pair
package encap_packet_pkg;
  localparam int DATA_WIDTH        = 1024;
  localparam int ADDR_WIDTH        = 10;
  localparam int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH;
  localparam int AURORA_DATA_WIDTH = 64;
  localparam int HEADER_WIDTH      = 9;
  localparam int PAYLOAD_PER_FRAME = AURORA_DATA_WIDTH - HEADER_WIDTH;
  localparam int NUM_FRAMES        = (DATA_DFX_WIDTH + PAYLOAD_PER_FRAME - 1) / PAYLOAD_PER_FRAME;
  localparam int LAST_FRAME_BITS   = DATA_DFX_WIDTH - (NUM_FRAMES - 1) * PAYLOAD_PER_FRAME;
  localparam int FRAME_CNT_WIDTH   = $clog2(NUM_FRAMES);
  localparam int PADDED_WIDTH      = NUM_FRAMES * PAYLOAD_PER_FRAME;
  typedef enum logic {IDLE, SEND} state_t;
  typedef logic [HEADER_WIDTH-1:0] header_t;
  // Zero-padding above the word makes the short last frame carry 0 in [63:53].
  function automatic logic [AURORA_DATA_WIDTH-1:0] frame_slice(
    input logic [DATA_DFX_WIDTH-1:0] d,
    input header_t h,
    input logic [FRAME_CNT_WIDTH-1:0] k
  );
    logic [PADDED_WIDTH-1:0] ext;
    ext = {{(PADDED_WIDTH-DATA_DFX_WIDTH){1'b0}}, d};
    return {ext[int'(k)*PAYLOAD_PER_FRAME +: PAYLOAD_PER_FRAME], h};
  endfunction
endpackage

// File: rtl/encap_packet.sv
// encap_packet: slices a 1034-bit DFX word into 19 headered 64-bit Aurora frames
module encap_packet
  import encap_packet_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_in,
  input  logic [HEADER_WIDTH-1:0]      header_pkt_in,
  input  logic                         dfx_valid,
  output logic                         dfx_ready,
  output logic [AURORA_DATA_WIDTH-1:0] tx_tdata,
  output logic                         tx_tvalid,
  output logic                         tx_tlast,
  input  logic                         tx_tready,
  output logic                         encap_done,
  output logic                         busy
);
  state_t state, state_n;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt, cnt_n;
  logic [DATA_DFX_WIDTH-1:0] data_q;
  header_t hdr_q;
  logic cap, fire, last;
  always_comb begin
    cap     = state == IDLE && dfx_valid && dfx_ready;
    fire    = state == SEND && tx_tready;
    last    = frame_cnt == FRAME_CNT_WIDTH'(NUM_FRAMES - 1);
    state_n = cap ? SEND : (fire && last) ? IDLE : state;
    cnt_n   = (fire && !last) ? frame_cnt + 1'b1 : (cap || fire) ? '0 : frame_cnt;
  end
  // Ready is registered so it stays low while rst_n is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      data_q     <= '0;
      hdr_q      <= '0;
      dfx_ready  <= 1'b0;
      encap_done <= 1'b0;
    end else begin
      state      <= state_n;
      frame_cnt  <= cnt_n;
      dfx_ready  <= state_n == IDLE;
      encap_done <= fire && last;
      if (cap) begin
        data_q <= data_dfx_in;
        hdr_q  <= header_pkt_in;
      end
    end
  end
  assign busy      = state == SEND;
  assign tx_tvalid = busy;
  assign tx_tlast  = busy && last;
  assign tx_tdata  = busy ? frame_slice(data_q, hdr_q, frame_cnt) : '0;
endmodule
